// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader: bit-serial configuration front-end for slicel.
// Deserialises an LSB-first bit stream into the CFG_TOTAL-bit slicel config word.
// The completed word is held in a shadow register that drives all *_out ports.
// It also sequences cen / reg_ce so that register init values latch before RUN.
// Ports:
//   cclk, rst_n                 clock, async active-low reset
//   cfg_start                   pulse: begin / restart a load
//   cfg_bit_in, cfg_bit_valid   serial data and qualifier
//   cfg_bit_ready               bit accepted this cycle when valid is high
//   cfg_busy, cfg_loaded        status (SHIFT/APPLY/HOLD, RUN)
//   luts_config_out ...         shadow word fields to slicel
//   cen, reg_ce                 slicel config enable / register clock enable
module slicel_cfg_loader #(
  parameter int unsigned S_XX_BASE   = 4,
  parameter int unsigned NUM_LUTS    = 4,
  parameter int unsigned MUX_LVLS    = $clog2(NUM_LUTS),
  parameter int unsigned CFG_SIZE    = 2 * (2 ** S_XX_BASE) + 1,
  parameter int unsigned CFG_TOTAL   = CFG_SIZE * NUM_LUTS + MUX_LVLS + 1 + 2 * NUM_LUTS,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                         cclk,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic                         cfg_bit_in,
  input  logic                         cfg_bit_valid,
  output logic                         cfg_bit_ready,
  output logic                         cfg_busy,
  output logic                         cfg_loaded,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_out,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config_out,
  output logic                         config_use_cc_out,
  output logic [2*NUM_LUTS-1:0]        regs_config_out,
  output logic                         cen,
  output logic                         reg_ce
);

  localparam int unsigned CntW  = $clog2(CFG_TOTAL + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned LutW  = CFG_SIZE * NUM_LUTS;
  localparam logic [CntW-1:0]  CntLast  = CntW'(CFG_TOTAL - 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES);

  typedef enum logic [2:0] {StUnconf, StShift, StApply, StHold, StRun} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [CFG_TOTAL-1:0]   shift_q, shift_d;
  logic [CFG_TOTAL-1:0]   shadow_q, shadow_d;
  logic                   accept;

  // A restart pulse in SHIFT wins over a bit presented in the same cycle.
  assign accept = (state_q == StShift) && cfg_bit_valid && !cfg_start;

  // State register
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StUnconf;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUnconf: if (cfg_start) state_d = StShift;
      StShift:  if (accept && (cnt_q == CntLast)) state_d = StApply;
      StApply:  state_d = StHold;
      StHold:   if (hold_q <= HoldW'(1)) state_d = StRun;
      StRun:    if (cfg_start) state_d = StShift;
      default:  state_d = StUnconf;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_bit_ready = 1'b0;
    cfg_busy      = 1'b0;
    cfg_loaded    = 1'b0;
    cen           = 1'b1;
    reg_ce        = 1'b0;
    unique case (state_q)
      StShift: begin
        cfg_bit_ready = 1'b1;
        cfg_busy      = 1'b1;
      end
      StApply, StHold: cfg_busy = 1'b1;
      StRun: begin
        cfg_loaded = 1'b1;
        cen        = 1'b0;
        reg_ce     = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    hold_d   = hold_q;
    if (state_q == StShift) begin
      if (cfg_start) begin
        cnt_d = '0;
      end else if (accept) begin
        cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        // Shift in at the MSB so the first bit ends up at word[0].
        shift_d = {cfg_bit_in, shift_q[CFG_TOTAL-1:1]};
      end
    end
    if (state_q == StApply) begin
      shadow_d = shift_q;
      hold_d   = HoldInit;
    end else if ((state_q == StHold) && (hold_q != '0)) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
    end
  end

  assign luts_config_out          = shadow_q[LutW-1:0];
  assign inter_lut_mux_config_out = shadow_q[LutW +: MUX_LVLS];
  assign config_use_cc_out        = shadow_q[LutW+MUX_LVLS];
  assign regs_config_out          = shadow_q[CFG_TOTAL-1 -: 2*NUM_LUTS];

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Bench for slicel_cfg_loader: two instances (HOLD_CYCLES 2 and 1) share stimulus.
// Expected words are queued when a load completes; monitors compare them on cfg_loaded rise.
module tb_slicel_cfg_loader;

  localparam int W = 143;

  logic cclk = 1'b0;
  logic rst_n, cfg_start, cfg_bit_in, cfg_bit_valid;

  logic         ready_a, busy_a, loaded_a, cen_a, reg_ce_a, use_cc_a;
  logic [131:0] luts_a;
  logic [1:0]   mux_a;
  logic [7:0]   regs_a;
  logic         ready_b, busy_b, loaded_b, cen_b, reg_ce_b, use_cc_b;
  logic [131:0] luts_b;
  logic [1:0]   mux_b;
  logic [7:0]   regs_b;

  logic [W-1:0] out_a, out_b;
  assign out_a = {regs_a, use_cc_a, mux_a, luts_a};
  assign out_b = {regs_b, use_cc_b, mux_b, luts_b};

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  logic [W-1:0] cur_word;

  logic [W-1:0] w1, w_ones, w_alt;

  always #5 cclk = ~cclk;

  slicel_cfg_loader #(.HOLD_CYCLES(2)) u_dut_a (
    .cclk                    (cclk),
    .rst_n                   (rst_n),
    .cfg_start               (cfg_start),
    .cfg_bit_in              (cfg_bit_in),
    .cfg_bit_valid           (cfg_bit_valid),
    .cfg_bit_ready           (ready_a),
    .cfg_busy                (busy_a),
    .cfg_loaded              (loaded_a),
    .luts_config_out         (luts_a),
    .inter_lut_mux_config_out(mux_a),
    .config_use_cc_out       (use_cc_a),
    .regs_config_out         (regs_a),
    .cen                     (cen_a),
    .reg_ce                  (reg_ce_a)
  );

  slicel_cfg_loader #(.HOLD_CYCLES(1)) u_dut_b (
    .cclk                    (cclk),
    .rst_n                   (rst_n),
    .cfg_start               (cfg_start),
    .cfg_bit_in              (cfg_bit_in),
    .cfg_bit_valid           (cfg_bit_valid),
    .cfg_bit_ready           (ready_b),
    .cfg_busy                (busy_b),
    .cfg_loaded              (loaded_b),
    .luts_config_out         (luts_b),
    .inter_lut_mux_config_out(mux_b),
    .config_use_cc_out       (use_cc_b),
    .regs_config_out         (regs_b),
    .cen                     (cen_b),
    .reg_ce                  (reg_ce_b)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: one expected word per rising cfg_loaded.
  logic prev_a = 1'b0, prev_b = 1'b0;
  always @(negedge cclk) begin
    if (rst_n === 1'b1 && loaded_a === 1'b1 && !prev_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_a: unexpected load got %h want none", out_a);
      end else begin
        chk("sb_a", out_a, q_a.pop_front());
      end
    end
    prev_a = (loaded_a === 1'b1);
  end
  always @(negedge cclk) begin
    if (rst_n === 1'b1 && loaded_b === 1'b1 && !prev_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_b: unexpected load got %h want none", out_b);
      end else begin
        chk("sb_b", out_b, q_b.pop_front());
      end
    end
    prev_b = (loaded_b === 1'b1);
  end

  task automatic do_start();
    @(negedge cclk);
    cfg_start     = 1'b1;
    cfg_bit_valid = 1'b0;
  endtask

  // Sends n bits of w; sparse idles every other cycle; gap_at inserts a 10-cycle gap.
  task automatic send_bits(input logic [W-1:0] w, input int n, input bit sparse,
                           input int gap_at);
    int i = 0;
    int cyc = 0;
    bit gapped = 1'b0;
    while (i < n) begin
      @(negedge cclk);
      cfg_start = 1'b0;
      chk("ready_shift_a", W'(ready_a), W'(1));
      chk("ready_shift_b", W'(ready_b), W'(1));
      if (i == 100) chk("out_hold_in_shift", out_a, cur_word);
      if (!gapped && i == gap_at) begin
        cfg_bit_valid = 1'b0;
        repeat (9) @(negedge cclk);
        chk("ready_in_gap", W'(ready_a), W'(1));
        gapped = 1'b1;
      end else if (sparse && (cyc % 2 == 1)) begin
        cfg_bit_valid = 1'b0;
      end else begin
        cfg_bit_valid = 1'b1;
        cfg_bit_in    = w[i];
        i++;
      end
      cyc++;
    end
  endtask

  // Checks APPLY/HOLD/RUN timing after the last bit was driven.
  task automatic finalize(input logic [W-1:0] nw);
    q_a.push_back(nw);
    q_b.push_back(nw);
    @(negedge cclk);  // after edge t (last accept)
    cfg_bit_valid = 1'b0;
    chk("out_old_in_apply", out_a, cur_word);
    chk("busy_apply", W'(busy_a), W'(1));
    chk("cen_a_t", W'(cen_a), W'(1));
    @(negedge cclk);  // after t+1
    chk("out_new_a", out_a, nw);
    chk("out_new_b", out_b, nw);
    chk("cen_a_t1", W'(cen_a), W'(1));
    chk("cen_b_t1", W'(cen_b), W'(1));
    @(negedge cclk);  // after t+2
    chk("cen_a_t2", W'(cen_a), W'(1));
    chk("cen_b_t2", W'(cen_b), W'(0));
    chk("reg_ce_b_t2", W'(reg_ce_b), W'(1));
    @(negedge cclk);  // after t+3
    chk("cen_a_t3", W'(cen_a), W'(0));
    chk("reg_ce_a_t3", W'(reg_ce_a), W'(1));
    chk("loaded_a_t3", W'(loaded_a), W'(1));
    cur_word = nw;
  endtask

  initial begin
    w1     = {8'b10100101, 1'b1, 2'b10, 132'h0_FFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0};
    w_ones = '1;
    w_alt  = {1'b0, {71{2'b10}}};
    cur_word      = '0;
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_bit_in    = 1'b0;
    cfg_bit_valid = 1'b0;
    #1;
    chk("rst_out", out_a, '0);
    chk("rst_cen", W'(cen_a), W'(1));
    chk("rst_reg_ce", W'(reg_ce_a), W'(0));
    chk("rst_status", W'({ready_a, busy_a, loaded_a}), W'(0));
    @(negedge cclk);
    rst_n = 1'b1;

    // Bits in UNCONF are ignored.
    repeat (5) begin
      @(negedge cclk);
      cfg_bit_valid = 1'b1;
      cfg_bit_in    = ~cfg_bit_in;
      chk("unconf_ready", W'({ready_a, ready_b}), W'(0));
    end

    // Test 1: contiguous stream
    do_start();
    send_bits(w1, W, 1'b0, -1);
    finalize(w1);
    chk("t1_regs", W'(regs_a), W'(8'hA5));
    chk("t1_use_cc", W'(use_cc_a), W'(1));
    chk("t1_mux", W'(mux_a), W'(2'b10));
    chk("t1_luts", W'(luts_a), W'(132'h0_FFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0));

    // Test 2: sparse valid with a long gap
    do_start();
    send_bits(w1, W, 1'b1, 70);
    finalize(w1);

    // Test 3: reconfigure from RUN with all ones
    do_start();
    @(negedge cclk);
    cfg_start = 1'b0;
    chk("t3_cen", W'(cen_a), W'(1));
    chk("t3_reg_ce", W'(reg_ce_a), W'(0));
    chk("t3_loaded", W'(loaded_a), W'(0));
    chk("t3_out_hold", out_a, cur_word);
    send_bits(w_ones, W, 1'b0, -1);
    finalize(w_ones);

    // Bits in RUN are ignored.
    repeat (10) begin
      @(negedge cclk);
      cfg_bit_valid = 1'b1;
      cfg_bit_in    = ~cfg_bit_in;
      chk("run_ready", W'({ready_a, ready_b}), W'(0));
    end
    @(negedge cclk);
    cfg_bit_valid = 1'b0;
    chk("run_out_keep", out_a, w_ones);
    chk("run_loaded", W'({loaded_a, loaded_b}), W'(2'b11));

    // Test 4: restart after 50 bits; the bit beside the restart pulse is discarded
    do_start();
    send_bits(w_ones, 50, 1'b0, -1);
    @(negedge cclk);
    cfg_start     = 1'b1;
    cfg_bit_valid = 1'b1;
    cfg_bit_in    = 1'b1;
    send_bits(w_alt, W, 1'b0, -1);
    finalize(w_alt);

    // Test 5: reset in the middle of a load
    do_start();
    send_bits(w1, 100, 1'b0, -1);
    @(negedge cclk);
    rst_n = 1'b0;
    #1;
    chk("t5_out_zero", out_a, '0);
    chk("t5_out_zero_b", out_b, '0);
    chk("t5_cen", W'(cen_a), W'(1));
    chk("t5_reg_ce", W'(reg_ce_a), W'(0));
    chk("t5_loaded", W'(loaded_a), W'(0));
    @(negedge cclk);
    rst_n    = 1'b1;
    cur_word = '0;
    repeat (20) begin
      @(negedge cclk);
      cfg_bit_valid = 1'b1;
      cfg_bit_in    = ~cfg_bit_in;
      chk("t5_unconf", W'({ready_a, busy_a, loaded_a, cen_a}), W'(4'b0001));
    end
    chk("t5_out_still_zero", out_a, '0);
    do_start();
    send_bits(w1, W, 1'b0, -1);
    finalize(w1);

    repeat (3) @(negedge cclk);
    chk("sb_drained", W'(q_a.size() + q_b.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slicel_cfg_loader.md
Name: slicel_cfg_loader

Overview:
Configuration front-end that sits directly upstream of slicel. It deserializes a bit-serial configuration stream into the 143-bit slicel config word and presents that word to slicel only once it is complete. It also sequences slicel's cen (config enable) and reg_ce so that register init values are latched before normal operation begins.

Parameters:
S_XX_BASE, 4, LUT input base; sets CFG_SIZE.
NUM_LUTS, 4, LUTs per slice.
MUX_LVLS, $clog2(NUM_LUTS), inter-LUT mux select bits.
CFG_SIZE, 2*(2**S_XX_BASE)+1, config bits per LUT (33).
CFG_TOTAL, CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS, total word length (143).
HOLD_CYCLES, 2, cycles cen stays high after a new word is applied (≥1).

Ports:
cclk  in  1  config clock; only clock of the block.
rst_n  in  1  asynchronous active-low reset.
cfg_start  in  1  single-cycle pulse; begin (or restart) loading a word.
cfg_bit_in  in  1  serial config data.
cfg_bit_valid  in  1  cfg_bit_in is valid.
cfg_bit_ready  out  1  loader accepts a bit this cycle.
cfg_busy  out  1  high in SHIFT, APPLY, HOLD.
cfg_loaded  out  1  high in RUN (valid config active).
luts_config_out  out  CFG_SIZE*NUM_LUTS  to slicel luts_config_in, word[131:0].
inter_lut_mux_config_out  out  MUX_LVLS  word[133:132].
config_use_cc_out  out  1  word[134].
regs_config_out  out  2*NUM_LUTS  word[142:135].
cen  out  1  to slicel cen; 1 = config/init phase.
reg_ce  out  1  to slicel reg_ce.

Behaviour:
- All state is reset asynchronously by rst_n low; state is sampled on posedge cclk.
- Reset values: state = UNCONF, bit counter = 0, shift register = 0, shadow word = 0 (all *_out = 0), cfg_bit_ready = 0, cfg_busy = 0, cfg_loaded = 0, cen = 1, reg_ce = 0.
- Bit order is LSB-first. The first accepted bit becomes word[0] and the 143rd becomes word[142]. The shift register shifts in at the MSB and shifts right.
- A bit is accepted on a posedge where cfg_bit_valid && cfg_bit_ready. Valid may drop for any number of cycles; no bit is lost or duplicated.
- The *_out ports are driven only from the shadow word. They never show a partial word, and they hold the previous word throughout SHIFT.
- States:
  - UNCONF: cen = 1, reg_ce = 0, ready = 0. cfg_start → SHIFT.
  - SHIFT: ready = 1, busy = 1, cen = 1, reg_ce = 0. Each accept increments the counter. Accepting bit CFG_TOTAL-1 → APPLY, and the counter clears.
  - APPLY (1 cycle): ready = 0. At the end of this cycle shadow <= shift register; *_out change at that edge. The hold counter loads HOLD_CYCLES → HOLD.
  - HOLD: cen = 1, reg_ce = 0. The hold counter decrements each cycle; when it reaches 0 → RUN.
  - RUN: cen = 0, reg_ce = 1, cfg_loaded = 1. cfg_start → SHIFT.
- Latency: if the last bit is accepted at edge t, *_out update at edge t+1, cen falls and reg_ce rises at edge t+1+HOLD_CYCLES.
- On entering SHIFT from RUN, cen rises and reg_ce and cfg_loaded fall at the same edge. Slicel registers are frozen during reconfiguration.
- cfg_start in SHIFT restarts the load: counter = 0, and any bit presented that same cycle is discarded. cfg_start in APPLY or HOLD is ignored.
- Bits presented outside SHIFT are ignored (ready = 0).
- rst_n asserted mid-operation (any state) returns to reset values immediately, including clearing the shadow word.
- Counter width is $clog2(CFG_TOTAL+1). It never exceeds CFG_TOTAL-1.

Test Plan:
1. Reset, cfg_start, then stream 143 bits with valid always high, word = {8'b10100101, 1'b1, 2'b10, 132'h0_FFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0} → regs_config_out = 8'hA5, config_use_cc_out = 1, inter_lut_mux_config_out = 2'b10, luts_config_out matches. *_out update 1 cycle after the last bit; cen falls and reg_ce rises 3 cycles after the last bit.
2. Same word with cfg_bit_valid toggling every other cycle, plus a 10-cycle gap at bit 70 → identical final word; cfg_bit_ready stays high throughout SHIFT.
3. From RUN, reconfigure with an all-ones word → cen = 1 and reg_ce = 0 from the first SHIFT edge. *_out hold the test-1 value until APPLY, then become all ones; cfg_loaded returns to 1.
4. Pulse cfg_start after 50 bits, then send a full 143-bit word of alternating 0/1 starting with 0 → the result is exactly that word (the first 50 bits are discarded). Exactly 143 accepts occur after the restart.
5. Assert rst_n low at bit 100 of a load → immediately all *_out = 0, cen = 1, reg_ce = 0, cfg_loaded = 0. After release, the state is UNCONF and ignores bits until cfg_start.
6. Configure with HOLD_CYCLES = 1 and set valid high outside SHIFT → bits are ignored in UNCONF/RUN; cen falls exactly 2 edges after the last bit.
